// File: rtl/rv32i_test_ctrl.sv
// Compliance-test sequencer for rv32i_core: seeds x1..x31 with addi words, streams the
// program image into memory, pulses core reset, then grades on ECALL or flags a timeout.
//
// state     | meaning
// IDLE      | waiting for start after reset
// INIT_REGS | writing addi xj,x0,0 for j=1..31 to words 0..30
// LOAD      | accepting image beats, each written one cycle after its handshake
// RST_HOLD  | core held in reset for RESET_CYCLES cycles
// RUN       | core running; counting cycles, watching for ECALL
// DONE      | result latched, core frozen until the next start
`timescale 1ns/1ps
module rv32i_test_ctrl #(
  parameter int          ADDR_W         = 12,
  parameter int          RESET_CYCLES   = 10,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter logic [31:0] PASS_VALUE     = 32'h1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [ADDR_W-1:0] img_addr,
  input  logic [31:0]       img_data,
  input  logic              img_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst_n,
  input  logic              is_ecall,
  input  logic [31:0]       gp_value,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_REGS, S_LOAD, S_RST_HOLD, S_RUN, S_DONE
  } state_e;

  localparam int                HOLD_W    = $clog2(RESET_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [15:0]       RUN_LIMIT = 16'(TIMEOUT_CYCLES);

  function automatic logic [31:0] addi_init(input logic [4:0] j);
    return {20'b0, j, 5'b00100, 2'b11};
  endfunction

  // Assertion follows rst immediately; release is retimed to clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int;

  state_e            state_q, state_d;
  logic [4:0]        init_j_q, init_j_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       run_cycles_q, run_cycles_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              img_hs;

  assign rst_sync_d = {rst_sync_q[0], 1'b0};
  assign rst_int    = rst_sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= rst_sync_d;
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      state_q      <= S_IDLE;
      init_j_q     <= '0;
      hold_q       <= '0;
      run_cycles_q <= '0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      timeout_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_j_q     <= init_j_d;
      hold_q       <= hold_d;
      run_cycles_q <= run_cycles_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      timeout_q    <= timeout_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign img_hs = img_valid && (state_q == S_LOAD);

  // Memory write fields are computed one cycle ahead so they are registered outputs.
  always_comb begin
    state_d      = state_q;
    init_j_d     = init_j_q;
    hold_d       = hold_q;
    run_cycles_d = run_cycles_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    timeout_d    = timeout_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_INIT_REGS;
          init_j_d     = 5'd1;
          run_cycles_d = '0;
          pass_d       = 1'b0;
          fail_d       = 1'b0;
          timeout_d    = 1'b0;
          mem_we_d     = 1'b1;
          mem_addr_d   = '0;
          mem_wdata_d  = addi_init(5'd1);
        end
      end
      S_INIT_REGS: begin
        if (init_j_q == 5'd31) begin
          state_d = S_LOAD;
        end else begin
          init_j_d    = init_j_q + 5'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(init_j_q);
          mem_wdata_d = addi_init(init_j_q + 5'd1);
        end
      end
      S_LOAD: begin
        if (img_hs) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = img_addr;
          mem_wdata_d = img_data;
          if (img_last) begin
            state_d = S_RST_HOLD;
            hold_d  = HOLD_LOAD;
          end
        end
      end
      S_RST_HOLD: begin
        if (hold_q == '0) begin
          state_d      = S_RUN;
          run_cycles_d = 16'd1;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (is_ecall) begin
          state_d = S_DONE;
          pass_d  = (gp_value == PASS_VALUE);
          fail_d  = (gp_value != PASS_VALUE);
        end else if (run_cycles_q == RUN_LIMIT) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          run_cycles_d = run_cycles_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    img_ready  = (state_q == S_LOAD);
    core_rst_n = (state_q == S_RUN);
    busy       = (state_q == S_INIT_REGS) || (state_q == S_LOAD) ||
                 (state_q == S_RST_HOLD)  || (state_q == S_RUN);
    done       = (state_q == S_DONE);
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign pass       = pass_q;
  assign fail       = fail_q;
  assign timeout    = timeout_q;
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_rv32i_test_ctrl.sv
// Bench for rv32i_test_ctrl: a table of test runs (fixed corner rows plus random rows)
// graded against an outcome model, with write-stream, reset-hold and abort checks.
`timescale 1ns/1ps
module tb_rv32i_test_ctrl;

  localparam int          ADDR_W         = 12;
  localparam int          RESET_CYCLES   = 10;
  localparam int          TIMEOUT_CYCLES = 5000;
  localparam logic [31:0] PASS_VALUE     = 32'h1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              img_valid;
  logic              img_ready;
  logic [ADDR_W-1:0] img_addr;
  logic [31:0]       img_data;
  logic              img_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              core_rst_n;
  logic              is_ecall;
  logic [31:0]       gp_value;
  logic              busy, done, pass, fail, timeout;
  logic [15:0]       run_cycles;

  rv32i_test_ctrl #(
    .ADDR_W(ADDR_W), .RESET_CYCLES(RESET_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .PASS_VALUE(PASS_VALUE)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .img_valid(img_valid), .img_ready(img_ready), .img_addr(img_addr),
    .img_data(img_data), .img_last(img_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .is_ecall(is_ecall), .gp_value(gp_value),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          ecall_cyc;   // RUN cycle with is_ecall=1, 0 = never
    logic [31:0] gp;
    int          nbeats;
    bit          fixed_img;   // single beat: addr 40, data 0x73
    bit          bp;          // random img_valid gaps
    bit          start_noise; // random start pulses during LOAD
    bit          exp_pass;
    bit          exp_fail;
    bit          exp_to;
    int          exp_run;
  } vec_t;

  vec_t vecs[$];

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outcome from the grading rules: ECALL within the window grades by gp, else timeout.
  function automatic vec_t graded(input vec_t v);
    vec_t r = v;
    if (v.ecall_cyc >= 1 && v.ecall_cyc <= TIMEOUT_CYCLES) begin
      r.exp_pass = (v.gp == PASS_VALUE);
      r.exp_fail = (v.gp != PASS_VALUE);
      r.exp_to   = 1'b0;
      r.exp_run  = v.ecall_cyc;
    end else begin
      r.exp_pass = 1'b0;
      r.exp_fail = 1'b0;
      r.exp_to   = 1'b1;
      r.exp_run  = TIMEOUT_CYCLES;
    end
    return r;
  endfunction

  function automatic vec_t mk(input int ec, input logic [31:0] gp, input int nb,
                              input bit fx, input bit bp, input bit sn,
                              input bit ep, input bit ef, input bit et, input int er);
    vec_t v;
    v.ecall_cyc = ec; v.gp = gp; v.nbeats = nb; v.fixed_img = fx; v.bp = bp;
    v.start_noise = sn; v.exp_pass = ep; v.exp_fail = ef; v.exp_to = et; v.exp_run = er;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk1({tag, "_core_rst_n"}, core_rst_n, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chkw({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chkw({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk1({tag, "_img_ready"}, img_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_pass"}, pass, 1'b0);
    chk1({tag, "_fail"}, fail, 1'b0);
    chk1({tag, "_timeout"}, timeout, 1'b0);
    chkw({tag, "_run_cycles"}, 32'(run_cycles), 32'h0);
  endtask

  task automatic run_test(input vec_t v, input int abort_at);
    logic [ADDR_W-1:0] baddr[8];
    logic [31:0]       bdata[8];
    bit                valid, hs;
    int                b, cyc, hold, k;

    for (int i = 0; i < 8; i++) begin
      baddr[i] = ADDR_W'($urandom_range(0, 63));
      bdata[i] = $urandom;
    end
    if (v.fixed_img) begin
      baddr[0] = ADDR_W'(40);
      bdata[0] = 32'h0000_0073;
    end

    start = 1'b1;
    tick();
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_done_clr", done, 1'b0);
    chk1("start_pass_clr", pass, 1'b0);
    chk1("start_fail_clr", fail, 1'b0);
    chk1("start_timeout_clr", timeout, 1'b0);
    chkw("start_run_cycles_clr", 32'(run_cycles), 32'h0);

    for (int j = 1; j <= 31; j++) begin
      chk1("init_we", mem_we, 1'b1);
      chkw("init_addr", 32'(mem_addr), 32'(j - 1));
      chkw("init_data", mem_wdata, (32'(j) << 7) | 32'h13);
      chk1("init_core_rst_n", core_rst_n, 1'b0);
      chk1("init_img_ready", img_ready, 1'b0);
      tick();
    end
    chk1("load_entry_we", mem_we, 1'b0);

    b = 0;
    cyc = 0;
    while (b < v.nbeats && cyc < 300) begin
      chk1("load_img_ready", img_ready, 1'b1);
      chk1("load_core_rst_n", core_rst_n, 1'b0);
      valid     = v.bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      img_valid = valid;
      img_addr  = valid ? baddr[b] : ADDR_W'($urandom);
      img_data  = valid ? bdata[b] : $urandom;
      img_last  = (b == v.nbeats - 1);
      start     = v.start_noise ? ($urandom_range(0, 3) == 0) : 1'b0;
      hs        = valid && img_ready;
      tick();
      chk1("load_we", mem_we, hs);
      if (hs) begin
        chkw("load_addr", 32'(mem_addr), 32'(baddr[b]));
        chkw("load_data", mem_wdata, bdata[b]);
        b++;
      end
      cyc++;
    end
    img_valid = 1'b0;
    img_last  = 1'b0;
    start     = 1'b0;
    if (b < v.nbeats) begin
      checks++;
      failures++;
      $display("FAIL load_budget beats_written=%0d required=%0d", b, v.nbeats);
    end

    hold = 0;
    do begin
      if (hold > 0) chk1("hold_we", mem_we, 1'b0);
      chk1("hold_img_ready", img_ready, 1'b0);
      chk1("hold_busy", busy, 1'b1);
      hold++;
      is_ecall = 1'($urandom_range(0, 1));
      gp_value = $urandom;
      tick();
    end while (!core_rst_n && hold < 64);
    is_ecall = 1'b0;
    chkw("rst_hold_len", 32'(hold), 32'(RESET_CYCLES));

    k = 1;
    while (1) begin
      chk1("run_core_rst_n", core_rst_n, 1'b1);
      chkw("run_cycles_count", 32'(run_cycles), 32'(k));
      chk1("run_done", done, 1'b0);
      chk1("run_we", mem_we, 1'b0);
      if (abort_at != 0 && k == abort_at) begin
        rst = 1'b1;
        #1;
        check_reset("abort");
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          chk1("post_abort_we", mem_we, 1'b0);
          chk1("post_abort_busy", busy, 1'b0);
        end
        return;
      end
      if (k == v.ecall_cyc) begin
        is_ecall = 1'b1;
        gp_value = v.gp;
      end else begin
        is_ecall = 1'b0;
        gp_value = $urandom;
      end
      tick();
      is_ecall = 1'b0;
      if (k >= v.exp_run) break;
      k++;
    end

    for (int i = 0; i < 4; i++) begin
      chk1("done_done", done, 1'b1);
      chk1("done_pass", pass, v.exp_pass);
      chk1("done_fail", fail, v.exp_fail);
      chk1("done_timeout", timeout, v.exp_to);
      chkw("done_run_cycles", 32'(run_cycles), 32'(v.exp_run));
      chk1("done_core_rst_n", core_rst_n, 1'b0);
      chk1("done_busy", busy, 1'b0);
      chk1("done_we", mem_we, 1'b0);
      is_ecall = 1'($urandom_range(0, 1));
      gp_value = $urandom;
      tick();
    end
    is_ecall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t abort_v;
    rst = 1'b0; start = 1'b0; img_valid = 1'b0; img_addr = '0; img_data = '0;
    img_last = 1'b0; is_ecall = 1'b0; gp_value = '0;
    #2 rst = 1'b1;
    repeat (3) tick();
    check_reset("por");
    rst = 1'b0;
    repeat (3) tick();
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_core_rst_n", core_rst_n, 1'b0);
    chk1("idle_img_ready", img_ready, 1'b0);

    //         ecall  gp            nb fx bp sn  pass fail to  run
    vecs.push_back(mk(7,    32'h1,  1, 1, 0, 0,  1,   0,   0,  7));
    vecs.push_back(mk(7,    32'h5,  3, 0, 1, 1,  0,   1,   0,  7));
    vecs.push_back(mk(0,    32'h0,  2, 0, 1, 0,  0,   0,   1,  5000));
    vecs.push_back(mk(5000, 32'h1,  1, 0, 0, 0,  1,   0,   0,  5000));
    vecs.push_back(mk(1,    32'h0,  4, 0, 1, 1,  0,   1,   0,  1));
    for (int i = 0; i < 5; i++) begin
      vec_t r;
      r = mk(int'($urandom_range(1, 60)),
             ($urandom_range(0, 1) == 1) ? PASS_VALUE : $urandom,
             int'($urandom_range(1, 6)), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
      vecs.push_back(graded(r));
    end

    foreach (vecs[i]) run_test(vecs[i], 0);

    abort_v = mk(0, 32'h1, 2, 0, 1, 0, 0, 0, 1, 5000);
    run_test(abort_v, 100);
    run_test(vecs[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_test_ctrl.md
Name: rv32i_test_ctrl

Overview:
Hardware sequencer that runs one compliance test on rv32i_core without testbench-side hierarchical pokes.
- Preloads register-init instructions into program memory, then streams a program image into it.
- Holds the core in reset for a fixed pulse, releases it, then watches for ECALL.
- Grades pass/fail from the gp register (x3), or flags a timeout.
- Sits between the host/bench and the core's memory write port and reset input.

Parameters:
ADDR_W, 12, word-address width of program memory
RESET_CYCLES, 10, cycles core_rst_n is held low before a run
TIMEOUT_CYCLES, 5000, maximum RUN cycles before timeout
PASS_VALUE, 32'h1, gp value that grades a test as pass

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a test
img_valid  in  1  image beat valid
img_ready  out  1  image beat accepted when img_valid & img_ready
img_addr  in  ADDR_W  word address of beat
img_data  in  32  instruction word
img_last  in  1  final beat of image
mem_we  out  1  program memory write enable
mem_addr  out  ADDR_W  program memory word address
mem_wdata  out  32  program memory write data
core_rst_n  out  1  active-low reset to rv32i_core
is_ecall  in  1  core decoding ECALL this cycle
gp_value  in  32  core regfile x3
busy  out  1  state not IDLE/DONE
done  out  1  level; result valid
pass  out  1  level; gp==PASS_VALUE at ECALL
fail  out  1  level; gp!=PASS_VALUE at ECALL
timeout  out  1  level; no ECALL in TIMEOUT_CYCLES
run_cycles  out  16  RUN cycles elapsed, frozen in DONE

Behaviour:
- Reset (async assert, sync deassert): state IDLE; core_rst_n=0, mem_we=0, mem_addr=0, mem_wdata=0, img_ready=0, busy/done/pass/fail/timeout=0, run_cycles=0. Reset mid-test aborts with no further memory writes.
- States: IDLE, INIT_REGS, LOAD, RST_HOLD, RUN, DONE. start is honoured only in IDLE or DONE and is ignored while busy.
- start in IDLE or DONE: clears done/pass/fail/timeout and run_cycles, moves to INIT_REGS. core_rst_n stays 0.
- INIT_REGS: 31 cycles, j=1..31, one write per cycle.
  - mem_addr=j-1.
  - mem_wdata={20'b0, j[4:0], 5'b00100, 2'b11}, i.e. addi xj,x0,0.
  - After j=31, go to LOAD.
- LOAD: img_ready=1. Each accepted beat is registered and appears on mem_we/mem_addr/mem_wdata exactly one cycle later.
  - Image writes may overwrite init words; the later write wins.
  - Accepted beat with img_last=1: go to RST_HOLD. That beat's write still issues the following cycle.
  - img_ready=0 in every other state.
- RST_HOLD: core_rst_n=0 for exactly RESET_CYCLES cycles, then RUN.
- RUN: core_rst_n=1; run_cycles increments each cycle starting at 1.
  - is_ecall=1: sample gp_value that cycle; set pass or fail; go to DONE.
  - Else, if run_cycles==TIMEOUT_CYCLES: set timeout; go to DONE.
  - ECALL and timeout in the same cycle: ECALL wins.
- DONE: done=1, core_rst_n=0 (core frozen); flags and run_cycles hold until start or rst.
- busy=1 in INIT_REGS, LOAD, RST_HOLD and RUN.
- mem_we is never asserted in RST_HOLD, RUN, DONE or IDLE, except for the trailing LOAD write.
- Exactly one of pass, fail and timeout is set whenever done=1. All three are 0 when done=0.

Test Plan:
- Init sequence: start, img_last on first beat (addr 40, data 0x00000073) -> 32 writes total; the first 31 are addr 0..30 with data 0x00000093, 0x00000113 … 0x00000F93; the final write is addr 40 = 0x73.
- Pass path: load image, hold is_ecall=0, raise is_ecall on RUN cycle 7 with gp=1 -> core_rst_n low exactly 10 cycles before RUN, done=pass=1, run_cycles=7, core_rst_n=0 next cycle.
- Fail path: same, gp=0x5 at ECALL -> fail=1, pass=0, timeout=0.
- Timeout: never assert is_ecall -> timeout=1 when run_cycles=5000; ECALL asserted on cycle 5000 instead -> pass/fail wins over timeout.
- Backpressure/start-ignore: toggle img_valid randomly, pulse start during LOAD -> writes are in order, one cycle after each handshake; start has no effect.
- Reset mid-RUN: assert rst at RUN cycle 100 -> all outputs return to reset values immediately; a new start runs a full clean sequence.
